// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback selection driving the register file write port.
// Optional macro WB_RETIRE_CNT_EN adds a 32-bit committed-write counter on the `retired` port.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_rfwr,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wdsel,
    input  logic [2:0]  in_memop,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_mem,
    input  logic [31:0] in_pc4,
    output logic        RFWr,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        misalign,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        MEMOP_LW  = 3'b000,
        MEMOP_LB  = 3'b001,
        MEMOP_LBU = 3'b010,
        MEMOP_LH  = 3'b011,
        MEMOP_LHU = 3'b100
    } memop_e;

    typedef enum logic [1:0] {
        WDSEL_ALU = 2'b00,
        WDSEL_MEM = 2'b01,
        WDSEL_PC4 = 2'b10,
        WDSEL_RSV = 2'b11
    } wdsel_e;

    logic        valid_q, valid_d;
    logic        rfwr_q, rfwr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wd_q, wd_d;
    logic        misal_q, misal_d;
    logic        written_q, written_d;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] sel_data;
    logic        misaligned_in;

    always_comb begin
        load_byte = in_mem[7:0];
        case (in_addr_lo)
            2'd1:    load_byte = in_mem[15:8];
            2'd2:    load_byte = in_mem[23:16];
            2'd3:    load_byte = in_mem[31:24];
            default: load_byte = in_mem[7:0];
        endcase
        load_half = in_addr_lo[1] ? in_mem[31:16] : in_mem[15:0];
    end

    // Unlisted memop encodings behave exactly like lw, including the alignment rule.
    always_comb begin
        load_data     = in_mem;
        misaligned_in = 1'b0;
        case (memop_e'(in_memop))
            MEMOP_LB:  load_data = {{24{load_byte[7]}}, load_byte};
            MEMOP_LBU: load_data = {24'd0, load_byte};
            MEMOP_LH: begin
                load_data     = {{16{load_half[15]}}, load_half};
                misaligned_in = in_addr_lo[0];
            end
            MEMOP_LHU: begin
                load_data     = {16'd0, load_half};
                misaligned_in = in_addr_lo[0];
            end
            default: begin
                load_data     = in_mem;
                misaligned_in = (in_addr_lo != 2'd0);
            end
        endcase
        if (wdsel_e'(in_wdsel) != WDSEL_MEM) begin
            misaligned_in = 1'b0;
        end
    end

    always_comb begin
        case (wdsel_e'(in_wdsel))
            WDSEL_MEM: sel_data = load_data;
            WDSEL_PC4: sel_data = in_pc4;
            default:   sel_data = in_alu;
        endcase
    end

    // Flush beats stall; a stalled instruction is held but marked as already written.
    always_comb begin
        valid_d   = valid_q;
        rfwr_d    = rfwr_q;
        rd_d      = rd_q;
        wd_d      = wd_q;
        misal_d   = misal_q;
        written_d = written_q;
        if (flush) begin
            valid_d   = 1'b0;
            rfwr_d    = 1'b0;
            rd_d      = 5'd0;
            wd_d      = 32'd0;
            misal_d   = 1'b0;
            written_d = 1'b0;
        end else if (stall) begin
            written_d = 1'b1;
        end else begin
            valid_d   = in_valid;
            rfwr_d    = in_rfwr;
            rd_d      = in_valid ? in_rd : 5'd0;
            wd_d      = in_valid ? sel_data : 32'd0;
            misal_d   = in_valid & misaligned_in;
            written_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rfwr_q    <= 1'b0;
            rd_q      <= 5'd0;
            wd_q      <= 32'd0;
            misal_q   <= 1'b0;
            written_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rfwr_q    <= rfwr_d;
            rd_q      <= rd_d;
            wd_q      <= wd_d;
            misal_q   <= misal_d;
            written_q <= written_d;
        end
    end

    assign RFWr      = valid_q & rfwr_q & (rd_q != 5'd0) & ~misal_q & ~written_q;
    assign A3        = rd_q;
    assign WD        = wd_q;
    assign misalign  = misal_q & ~written_q;
    assign fwd_valid = RFWr;
    assign fwd_rd    = A3;
    assign fwd_data  = WD;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q + {31'd0, RFWr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven self-checking bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic        in_rfwr;
   logic [4:0]  in_rd;
   logic [1:0]  in_wdsel;
   logic [2:0]  in_memop;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu;
   logic [31:0] in_mem;
   logic [31:0] in_pc4;
   logic        RFWr;
   logic [4:0]  A3;
   logic [31:0] WD;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        misalign;
   logic [31:0] retired;

   int checks;
   int failures;

   wb_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .stall     (stall),
      .flush     (flush),
      .in_rfwr   (in_rfwr),
      .in_rd     (in_rd),
      .in_wdsel  (in_wdsel),
      .in_memop  (in_memop),
      .in_addr_lo(in_addr_lo),
      .in_alu    (in_alu),
      .in_mem    (in_mem),
      .in_pc4    (in_pc4),
      .RFWr      (RFWr),
      .A3        (A3),
      .WD        (WD),
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data),
      .misalign  (misalign),
      .retired   (retired)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic        valid;
      logic        rfwr;
      logic [4:0]  rd;
      logic [1:0]  wdsel;
      logic [2:0]  memop;
      logic [1:0]  addr_lo;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] pc4;
      logic        e_rfwr;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic        e_mis;
   } vec_t;

   vec_t vecs[14];

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Compares every writeback and forwarding output against the expected commit.
   task automatic checkOutput(input string name, input logic e_rfwr, input logic [4:0] e_a3,
                              input logic [31:0] e_wd, input logic e_mis);
      checkField({name, ".RFWr"}, {31'd0, RFWr}, {31'd0, e_rfwr});
      checkField({name, ".A3"}, {27'd0, A3}, {27'd0, e_a3});
      checkField({name, ".WD"}, WD, e_wd);
      checkField({name, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
      checkField({name, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, e_rfwr});
      checkField({name, ".fwd_rd"}, {27'd0, fwd_rd}, {27'd0, e_a3});
      checkField({name, ".fwd_data"}, fwd_data, e_wd);
   endtask

   // Advances one rising edge and settles just after it.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Drives one vector as a normal capture and clocks it in.
   task automatic applyStimulus(input vec_t v);
      in_valid   = v.valid;
      in_rfwr    = v.rfwr;
      in_rd      = v.rd;
      in_wdsel   = v.wdsel;
      in_memop   = v.memop;
      in_addr_lo = v.addr_lo;
      in_alu     = v.alu;
      in_mem     = v.mem;
      in_pc4     = v.pc4;
      stall      = 1'b0;
      flush      = 1'b0;
      stepClock();
   endtask

   task automatic captureAlu(input logic [4:0] rd, input logic [31:0] alu);
      vec_t v;
      v = '{"cap", 1'b1, 1'b1, rd, 2'b00, 3'b000, 2'd0, alu, 32'd0, 32'd0, 1'b1, rd, alu, 1'b0};
      applyStimulus(v);
   endtask

   logic [31:0] retired_base;

   initial begin
      checks   = 0;
      failures = 0;

      //          name        vld  rfwr rd     wdsel  memop   alo   alu           mem           pc4           eRF  eA3    eWD           eMis
      vecs[0]  = '{"alu",     1'b1,1'b1,5'd5,  2'b00, 3'b000, 2'd0, 32'h12345678, 32'h0,        32'h0,        1'b1,5'd5,  32'h12345678, 1'b0};
      vecs[1]  = '{"bubble",  1'b0,1'b1,5'd5,  2'b00, 3'b000, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0,5'd0,  32'h0,        1'b0};
      vecs[2]  = '{"lb_a1",   1'b1,1'b1,5'd3,  2'b01, 3'b001, 2'd1, 32'h0,        32'h80FF7F01, 32'h0,        1'b1,5'd3,  32'h0000007F, 1'b0};
      vecs[3]  = '{"lb_a3",   1'b1,1'b1,5'd3,  2'b01, 3'b001, 2'd3, 32'h0,        32'h80FF7F01, 32'h0,        1'b1,5'd3,  32'hFFFFFF80, 1'b0};
      vecs[4]  = '{"lbu_a2",  1'b1,1'b1,5'd6,  2'b01, 3'b010, 2'd2, 32'h0,        32'h80FF7F01, 32'h0,        1'b1,5'd6,  32'h000000FF, 1'b0};
      vecs[5]  = '{"lh_a2",   1'b1,1'b1,5'd8,  2'b01, 3'b011, 2'd2, 32'h0,        32'h80011234, 32'h0,        1'b1,5'd8,  32'hFFFF8001, 1'b0};
      vecs[6]  = '{"lhu_a0",  1'b1,1'b1,5'd8,  2'b01, 3'b100, 2'd0, 32'h0,        32'h80011234, 32'h0,        1'b1,5'd8,  32'h00001234, 1'b0};
      vecs[7]  = '{"lw_mis",  1'b1,1'b1,5'd4,  2'b01, 3'b000, 2'd2, 32'h0,        32'hA5A5A5A5, 32'h0,        1'b0,5'd4,  32'hA5A5A5A5, 1'b1};
      vecs[8]  = '{"rd0_pc4", 1'b1,1'b1,5'd0,  2'b10, 3'b000, 2'd0, 32'h0,        32'h0,        32'h00000040, 1'b0,5'd0,  32'h00000040, 1'b0};
      vecs[9]  = '{"wdsel11", 1'b1,1'b1,5'd31, 2'b11, 3'b000, 2'd0, 32'hDEADBEEF, 32'h0,        32'h0,        1'b1,5'd31, 32'hDEADBEEF, 1'b0};
      vecs[10] = '{"lh_mis",  1'b1,1'b1,5'd9,  2'b01, 3'b011, 2'd1, 32'h0,        32'h80011234, 32'h0,        1'b0,5'd9,  32'h00001234, 1'b1};
      vecs[11] = '{"lb_neg",  1'b1,1'b1,5'd2,  2'b01, 3'b001, 2'd0, 32'h0,        32'h000000F0, 32'h0,        1'b1,5'd2,  32'hFFFFFFF0, 1'b0};
      vecs[12] = '{"memop7",  1'b1,1'b1,5'd11, 2'b01, 3'b111, 2'd0, 32'h0,        32'hCAFEF00D, 32'h0,        1'b1,5'd11, 32'hCAFEF00D, 1'b0};
      vecs[13] = '{"alu_a3",  1'b1,1'b0,5'd12, 2'b00, 3'b000, 2'd3, 32'h0BADF00D, 32'h0,        32'h0,        1'b0,5'd12, 32'h0BADF00D, 1'b0};

      rst        = 1'b1;
      in_valid   = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      in_rfwr    = 1'b0;
      in_rd      = 5'd0;
      in_wdsel   = 2'd0;
      in_memop   = 3'd0;
      in_addr_lo = 2'd0;
      in_alu     = 32'd0;
      in_mem     = 32'd0;
      in_pc4     = 32'd0;
      stepClock();
      stepClock();
      checkOutput("reset", 1'b0, 5'd0, 32'd0, 1'b0);
      checkField("reset.retired", retired, 32'd0);
      rst = 1'b0;

      $display("[TB] applying %0d table vectors", $size(vecs));
      for (int i = 0; i < $size(vecs); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, vecs[i].e_rfwr, vecs[i].e_a3, vecs[i].e_wd, vecs[i].e_mis);
      end

      // Misalign pulses only in the capture cycle, never in a held cycle.
      applyStimulus(vecs[7]);
      checkOutput("mis_cap", 1'b0, 5'd4, 32'hA5A5A5A5, 1'b1);
      stall = 1'b1;
      stepClock();
      checkOutput("mis_hold", 1'b0, 5'd4, 32'hA5A5A5A5, 1'b0);
      stall = 1'b0;

      // A stalled instruction commits exactly once.
      captureAlu(5'd7, 32'h00000077);
      checkOutput("stall_cap", 1'b1, 5'd7, 32'h00000077, 1'b0);
      retired_base = retired;
      in_valid = 1'b0;
      in_alu   = 32'd0;
      stall    = 1'b1;
      for (int c = 0; c < 3; c++) begin
         stepClock();
         checkOutput($sformatf("stall_hold%0d", c), 1'b0, 5'd7, 32'h00000077, 1'b0);
      end
      stall = 1'b0;
      stepClock();
      checkOutput("stall_after", 1'b0, 5'd0, 32'd0, 1'b0);
`ifdef WB_RETIRE_CNT_EN
      checkField("stall.retired_delta", retired - retired_base, 32'd1);
`else
      checkField("stall.retired_tied", retired, 32'd0);
`endif

      // Flush wins over stall.
      captureAlu(5'd9, 32'h00000099);
      checkOutput("fs_cap", 1'b1, 5'd9, 32'h00000099, 1'b0);
      stall = 1'b1;
      flush = 1'b1;
      stepClock();
      checkOutput("flush_stall", 1'b0, 5'd0, 32'd0, 1'b0);
      stall = 1'b0;
      flush = 1'b0;

      // Reset during a stall drops the pending instruction.
      captureAlu(5'd10, 32'h000000AA);
      checkOutput("rs_cap", 1'b1, 5'd10, 32'h000000AA, 1'b0);
      stall = 1'b1;
      stepClock();
      checkOutput("rs_hold", 1'b0, 5'd10, 32'h000000AA, 1'b0);
      rst = 1'b1;
      stepClock();
      checkOutput("rs_reset", 1'b0, 5'd0, 32'd0, 1'b0);
      checkField("rs_reset.retired", retired, 32'd0);
      rst   = 1'b0;
      stall = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
